// File: rtl/blink_sequencer_if.sv
// Control/program bus between the switch/button front end and the blink step sequencer.
// The master drives the start/stop/loop/program-write controls. The slave drives the blinker controls and the status outputs.
interface blink_sequencer_if #(
   parameter int c_STEPS = 4
);
   localparam int c_AW = $clog2(c_STEPS);

   logic            i_start;
   logic            i_stop;
   logic            i_loop;
   logic            i_wr_en;
   logic [c_AW-1:0] i_wr_addr;
   logic [7:0]      i_wr_data;

   logic            o_enable;
   logic            o_select0;
   logic            o_select1;
   logic            o_busy;
   logic [c_AW-1:0] o_step;
   logic            o_done;

   modport master (
      output i_start, i_stop, i_loop, i_wr_en, i_wr_addr, i_wr_data,
      input  o_enable, o_select0, o_select1, o_busy, o_step, o_done
   );

   modport slave (
      input  i_start, i_stop, i_loop, i_wr_en, i_wr_addr, i_wr_data,
      output o_enable, o_select0, o_select1, o_busy, o_step, o_done
   );
endinterface

// File: rtl/blink_sequencer.sv
// Plays a small register-file program of {enable, select1, select0, duration} steps into the LED blinker.
//
// state  | meaning
// S_IDLE | waiting for start; blinker controls low, step index holds
// S_LOAD | one cycle; step outputs and tick count already loaded on entry
// S_RUN  | prescaler and tick down-counters timing the current step
// S_DONE | one-cycle completion pulse, then back to idle
module blink_sequencer #(
   parameter int c_TICK_DIV = 5_000_000,
   parameter int c_STEPS    = 4
) (
   input logic              i_clk,
   input logic              i_reset_n,
   blink_sequencer_if.slave bus
);
   localparam int              c_AW     = $clog2(c_STEPS);
   localparam int              c_PW     = $clog2(c_TICK_DIV);
   localparam logic [c_PW-1:0] c_PRE_TC = c_PW'(c_TICK_DIV - 1);
   localparam logic [c_AW-1:0] c_LAST   = c_AW'(c_STEPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [7:0]      prog [c_STEPS];
   logic [c_AW-1:0] step, step_nxt;
   logic [c_PW-1:0] pre;
   logic [4:0]      tick;
   logic [2:0]      bits;
   logic            busy, done;
   logic            load, end_step;

   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      load      = 1'b0;
      end_step  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.i_start) begin
               state_nxt = S_LOAD;
               step_nxt  = '0;
               load      = 1'b1;
            end
         end
         S_LOAD: begin
            if (tick == '0) end_step = 1'b1;
            else            state_nxt = S_RUN;
         end
         S_RUN: begin
            if (pre == '0 && tick == 5'd1) end_step = 1'b1;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (end_step) begin
         if (step != c_LAST) begin
            step_nxt  = step + c_AW'(1);
            state_nxt = S_LOAD;
            load      = 1'b1;
         end else if (bus.i_loop) begin
            step_nxt  = '0;
            state_nxt = S_LOAD;
            load      = 1'b1;
         end else begin
            state_nxt = S_DONE;
         end
      end
      // abort overrides everything, but an idle sequencer ignores it so start can win
      if (bus.i_stop && state != S_IDLE) begin
         state_nxt = S_IDLE;
         step_nxt  = step;
         load      = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < c_STEPS; i++) prog[i] <= '0;
      end else if (bus.i_wr_en) begin
         prog[bus.i_wr_addr] <= bus.i_wr_data;
      end
   end

   // Step data is captured on the edge entering LOAD. A same-cycle write therefore lands after the read.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= S_IDLE;
         step  <= '0;
         pre   <= '0;
         tick  <= '0;
         bits  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         step  <= step_nxt;
         busy  <= (state_nxt == S_LOAD) || (state_nxt == S_RUN);
         done  <= (state_nxt == S_DONE);
         if (load) begin
            bits <= prog[step_nxt][7:5];
            tick <= prog[step_nxt][4:0];
         end else begin
            if (state_nxt == S_IDLE || state_nxt == S_DONE) bits <= '0;
            if (state == S_RUN && pre == '0) tick <= tick - 5'd1;
         end
         if (state == S_LOAD)     pre <= c_PRE_TC;
         else if (state == S_RUN) pre <= (pre == '0) ? c_PRE_TC : pre - c_PW'(1);
      end
   end

   assign bus.o_enable  = bits[2];
   assign bus.o_select1 = bits[1];
   assign bus.o_select0 = bits[0];
   assign bus.o_busy    = busy;
   assign bus.o_done    = done;
   assign bus.o_step    = step;
endmodule
